// File: rtl/serial_add_sequencer_if.sv
// Request/result handshake bundle between bus-side requesters and the serial add sequencer.
interface serial_add_sequencer_if #(
  parameter int WIDTH = 8
) ();
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_cin;
  logic             req_sub;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_ovf;

  modport master (
    output req_valid, req_a, req_b, req_cin, req_sub, res_ready,
    input  req_ready, res_valid, res_sum, res_cout, res_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_sub, res_ready,
    output req_ready, res_valid, res_sum, res_cout, res_ovf
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// Word-level controller that streams an add/subtract LSB-first through an external
// one-bit registered serial full-adder slice and reassembles the result.
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_add_sequencer_if.slave bus,
  output logic                  busy,
  output logic                  add_a,
  output logic                  add_b,
  output logic                  add_cin,
  input  logic                  add_sum,
  input  logic                  add_cout
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry0_q, carry0_d;
  logic             msb_cin_q, msb_cin_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] acc_next;

  // The slice registers its outputs, so each sum bit lands one cycle after its operands.
  assign acc_next = {add_sum, acc_q[WIDTH-1:1]};

  assign add_a   = (state_q == RUN) & a_q[0];
  assign add_b   = (state_q == RUN) & b_q[0];
  assign add_cin = (state_q == RUN) & ((idx_q == '0) ? carry0_q : add_cout);

  assign bus.req_ready = (state_q == IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_sum   = sum_q;
  assign bus.res_cout  = cout_q;
  assign bus.res_ovf   = ovf_q;
  assign busy          = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    carry0_d  = carry0_q;
    msb_cin_d = msb_cin_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          a_d      = bus.req_a;
          b_d      = bus.req_sub ? ~bus.req_b : bus.req_b;
          carry0_d = bus.req_sub | bus.req_cin;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        idx_d = idx_q + 1'b1;
        if (idx_q != '0) begin
          acc_d = acc_next;
        end
        // Carry into the MSB is kept for the signed-overflow test at the end of FLUSH.
        if (idx_q == LAST_IDX) begin
          msb_cin_d = add_cin;
          idx_d     = '0;
          state_d   = FLUSH;
        end
      end
      FLUSH: begin
        acc_d   = acc_next;
        sum_d   = acc_next;
        cout_d  = add_cout;
        ovf_d   = add_cout ^ msb_cin_q;
        state_d = DONE;
      end
      default: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      carry0_q  <= 1'b0;
      msb_cin_q <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      carry0_q  <= carry0_d;
      msb_cin_q <= msb_cin_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Randomized self-checking bench for serial_add_sequencer with a behavioural serial
// adder slice and a plain-arithmetic reference model.
module tb_serial_add_sequencer;
  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  logic busy;
  logic add_a, add_b, add_cin;
  logic add_sum, add_cout;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  serial_add_sequencer_if #(.WIDTH(WIDTH)) bus ();

  serial_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stand-in for the registered one-bit full-adder slice.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      add_sum  <= 1'b0;
      add_cout <= 1'b0;
    end else begin
      add_sum  <= add_a ^ add_b ^ add_cin;
      add_cout <= (add_a & add_b) | (add_a & add_cin) | (add_b & add_cin);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                input logic sub, output logic [7:0] s, output logic co,
                                output logic ov);
    int ua, ub, sa, sb, r, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      r  = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub + int'(cin);
      co = (r > 255);
      sr = sa + sb + int'(cin);
    end
    s  = r[7:0];
    ov = (sr > 127) || (sr < -128);
  endfunction

  task automatic accept_req(input logic [7:0] a, input logic [7:0] b, input logic cin,
                            input logic sub, output int n0);
    int waited = 0;
    @(negedge clk);
    while (!bus.req_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) check_output("accept_timeout", 32'd0, 32'd1);
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_cin   = cin;
    bus.req_sub   = sub;
    bus.req_valid = 1'b1;
    n0 = cyc;
    @(posedge clk);
  endtask

  task automatic wait_result(input int n0, input logic [7:0] a, input logic [7:0] b,
                             input logic cin, input logic sub, input string tag);
    logic [7:0] es;
    logic       ec, eo;
    int         waited = 0;
    model(a, b, cin, sub, es, ec, eo);
    @(negedge clk);
    while (!bus.res_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.res_valid) begin
      check_output({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check_output({tag, "_latency"}, 32'(cyc - n0 - 1), 32'd9);
    check_output({tag, "_sum"}, 32'(bus.res_sum), 32'(es));
    check_output({tag, "_cout"}, 32'(bus.res_cout), 32'(ec));
    check_output({tag, "_ovf"}, 32'(bus.res_ovf), 32'(eo));
  endtask

  task automatic release_result(input string tag);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check_output({tag, "_valid_drop"}, 32'(bus.res_valid), 32'd0);
    check_output({tag, "_ready_back"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                input logic sub, input string tag);
    int n0;
    accept_req(a, b, cin, sub, n0);
    #1 bus.req_valid = 1'b0;
    wait_result(n0, a, b, cin, sub, tag);
    release_result(tag);
  endtask

  initial begin
    int         n0, n1, prev;
    logic [7:0] ra, rb, es;
    logic       rc, rs, ec, eo;

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = 1'b0;
    bus.req_sub   = 1'b0;
    bus.res_ready = 1'b0;
    #12;
    check_output("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_output("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_output("rst_res_sum", 32'(bus.res_sum), 32'd0);
    check_output("rst_res_cout", 32'(bus.res_cout), 32'd0);
    check_output("rst_res_ovf", 32'(bus.res_ovf), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_add_pins", {29'd0, add_a, add_b, add_cin}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    apply_stimulus(8'h5A, 8'h33, 1'b0, 1'b0, "add_5a_33");
    apply_stimulus(8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
    apply_stimulus(8'h7F, 8'h00, 1'b1, 1'b0, "add_7f_cin");
    apply_stimulus(8'h10, 8'h20, 1'b0, 1'b1, "sub_10_20");
    apply_stimulus(8'h80, 8'h01, 1'b0, 1'b1, "sub_80_01");
    apply_stimulus(8'h10, 8'h20, 1'b1, 1'b1, "sub_cin_ignored");

    // Stall the result consumer while new requests knock on the door.
    model(8'h3C, 8'h42, 1'b0, 1'b0, es, ec, eo);
    accept_req(8'h3C, 8'h42, 1'b0, 1'b0, n0);
    #1 bus.req_valid = 1'b0;
    wait_result(n0, 8'h3C, 8'h42, 1'b0, 1'b0, "hold");
    for (int i = 0; i < 5; i++) begin
      bus.req_a     = 8'h11;
      bus.req_b     = 8'h22;
      bus.req_cin   = 1'b0;
      bus.req_sub   = 1'b0;
      bus.req_valid = 1'b1;
      @(negedge clk);
      check_output("hold_valid", 32'(bus.res_valid), 32'd1);
      check_output("hold_ready", 32'(bus.req_ready), 32'd0);
      check_output("hold_sum", 32'(bus.res_sum), 32'(es));
      check_output("hold_cout", 32'(bus.res_cout), 32'(ec));
    end
    release_result("hold");
    check_output("hold_retain", 32'(bus.res_sum), 32'(es));
    n1 = cyc;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wait_result(n1, 8'h11, 8'h22, 1'b0, 1'b0, "held_req");
    release_result("held_req");

    // Abort mid-operation with an asynchronous reset in RUN cycle 4.
    accept_req(8'hAA, 8'h55, 1'b0, 1'b0, n0);
    #1 bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check_output("abort_res_valid", 32'(bus.res_valid), 32'd0);
    check_output("abort_res_sum", 32'(bus.res_sum), 32'd0);
    check_output("abort_flags", {30'd0, bus.res_cout, bus.res_ovf}, 32'd0);
    check_output("abort_add_pins", {29'd0, add_a, add_b, add_cin}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(8'h01, 8'h01, 1'b0, 1'b0, "post_reset");

    // Back-to-back random traffic with the consumer always ready.
    bus.res_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      rc = 1'($urandom_range(1));
      rs = 1'($urandom_range(1));
      accept_req(ra, rb, rc, rs, n0);
      if (i > 0) check_output("b2b_interval", 32'(n0 - prev), 32'd11);
      prev = n0;
      wait_result(n0, ra, rb, rc, rs, "b2b");
    end
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    bus.res_ready = 1'b0;
    check_output("end_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
